// File: rtl/seg_display_arbiter_if.sv
// Request bundle between display sources and seg_display_arbiter.
// Ports: req_valid / req_value from sources, req_ready one-hot back.
interface seg_display_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int VALUE_W = 14
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*VALUE_W-1:0] req_value;
  logic [NUM_REQ-1:0]         req_ready;

  modport master (
    output req_valid,
    output req_value,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_value,
    output req_ready
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Fixed-priority arbiter sharing a 4-digit display, with hold time
// and a sequential double-dabble binary-to-BCD converter.
// Ports: i_clk, i_reset (sync, active high), req_if (slave side of
//   the request bundle), o_digits (BCD), o_digit_blank,
//   o_disp_valid, o_active_src, o_busy.
// Optional: SEG_LEAD_ZERO_BLANK_EN blanks leading zero digits.
module seg_display_arbiter #(
  parameter  int          NUM_REQ     = 3,
  parameter  int          VALUE_W     = 14,
  parameter  int unsigned HOLD_CYCLES = 100000000,
  localparam int          SRC_W       =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  seg_display_arbiter_if.slave   req_if,
  output logic [15:0]            o_digits,
  output logic [3:0]             o_digit_blank,
  output logic                   o_disp_valid,
  output logic [SRC_W-1:0]       o_active_src,
  output logic                   o_busy
);

  localparam int          CNT_W    = $clog2(VALUE_W + 1);
  localparam int unsigned HOLD_EFF =
    (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam logic [31:0] MAX_V    = 32'd9999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_CONVERT,
    S_SHOW
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [VALUE_W-1:0] r_bin;
  logic [15:0]        r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [SRC_W-1:0]   r_src;
  logic [31:0]        r_hold;
  logic [15:0]        r_digits;
  logic [3:0]         r_blank;
  logic               r_disp_valid;
  logic [SRC_W-1:0]   r_active;

  logic               w_any;
  logic [SRC_W-1:0]   w_gidx;
  logic [NUM_REQ-1:0] w_grant;
  logic [VALUE_W-1:0] w_gval;
  logic [VALUE_W-1:0] w_clamped;
  logic [15:0]        w_adj;
  logic [15:0]        w_bcd_nx;
  logic [3:0]         w_blank_nx;
  logic               w_last;

  // Lowest asserted index wins.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_if.req_valid[i]) begin
        w_any  = 1'b1;
        w_gidx = SRC_W'(i);
      end
    end
  end

  assign w_grant = w_any ?
    (NUM_REQ'(1) << w_gidx) : '0;

  assign w_gval =
    req_if.req_value[w_gidx*VALUE_W +: VALUE_W];

  assign w_clamped = (32'(w_gval) > MAX_V) ?
    VALUE_W'(MAX_V) : w_gval;

  function automatic logic [15:0] add3(
    input logic [15:0] b
  );
    logic [15:0] r;
    r = b;
    for (int k = 0; k < 4; k++) begin
      if (r[k*4 +: 4] >= 4'd5)
        r[k*4 +: 4] = r[k*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // One double-dabble iteration: add-3 then shift in next bin MSB.
  assign w_adj    = add3(r_bcd);
  assign w_bcd_nx = {w_adj[14:0], r_bin[VALUE_W-1]};
  assign w_last   = (r_cnt == CNT_W'(VALUE_W - 1));

`ifdef SEG_LEAD_ZERO_BLANK_EN
  always_comb begin
    w_blank_nx    = 4'b0000;
    w_blank_nx[3] = (w_bcd_nx[15:12] == 4'd0);
    w_blank_nx[2] = w_blank_nx[3] &
                    (w_bcd_nx[11:8] == 4'd0);
    w_blank_nx[1] = w_blank_nx[2] &
                    (w_bcd_nx[7:4] == 4'd0);
  end
`else
  assign w_blank_nx = 4'b0000;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_any) w_next = S_CAPTURE;
      S_CAPTURE:
        w_next = w_any ? S_CONVERT : S_IDLE;
      S_CONVERT:
        if (w_last) w_next = S_SHOW;
      S_SHOW:
        if (r_hold == 32'd0)
          w_next = w_any ? S_CAPTURE : S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_src        <= '0;
      r_hold       <= '0;
      r_digits     <= '0;
      r_blank      <= '0;
      r_disp_valid <= 1'b0;
      r_active     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CAPTURE && w_any) begin
        r_bin <= w_clamped;
        r_bcd <= '0;
        r_cnt <= '0;
        r_src <= w_gidx;
      end
      if (r_state == S_CONVERT) begin
        r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
        r_bcd <= w_bcd_nx;
        r_cnt <= r_cnt + CNT_W'(1);
        // Outputs change only once the full result exists.
        if (w_last) begin
          r_digits     <= w_bcd_nx;
          r_blank      <= w_blank_nx;
          r_disp_valid <= 1'b1;
          r_active     <= r_src;
          r_hold       <= 32'(HOLD_EFF - 1);
        end
      end
      if (r_state == S_SHOW && r_hold != 32'd0)
        r_hold <= r_hold - 32'd1;
    end
  end

  assign req_if.req_ready =
    (r_state == S_CAPTURE) ? w_grant : '0;

  assign o_digits      = r_digits;
  assign o_digit_blank = r_blank;
  assign o_disp_valid  = r_disp_valid;
  assign o_active_src  = r_active;
  assign o_busy        = (r_state == S_CONVERT);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a grant-to-display
// scoreboard; HOLD_CYCLES=8, NUM_REQ=3, VALUE_W=14.
module tb_seg_display_arbiter;

  localparam int NR   = 3;
  localparam int VW   = 14;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        dvalid;
  logic [1:0]  asrc;
  logic        busy;

  seg_display_arbiter_if #(.NUM_REQ(NR), .VALUE_W(VW)) rif();

  seg_display_arbiter #(
    .NUM_REQ(NR), .VALUE_W(VW), .HOLD_CYCLES(HOLD)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .req_if(rif),
    .o_digits(digits),
    .o_digit_blank(blank),
    .o_disp_valid(dvalid),
    .o_active_src(asrc),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [15:0] dig;
    logic [3:0]  blk;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   g_total = 0;
  bit   granted = 0;
  bit   shown = 0;
  bit   prev_busy = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10),
            4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [3:0] m_blank(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
`ifdef SEG_LEAD_ZERO_BLANK_EN
    return {c < 1000, c < 100, c < 10, 1'b0};
`else
    return (c < 0) ? 4'hF : 4'h0;
`endif
  endfunction

  task automatic set_val(input int i, input int v);
    rif.req_value[i*VW +: VW] = VW'(v);
  endtask

  // One clock; sample 1 time unit after the edge, run scoreboard.
  task automatic tick();
    int          s;
    int          v;
    logic [2:0]  er;
    exp_t        e;
    @(posedge clk);
    #1;
    cyc++;
    granted = 0;
    shown   = 0;
    if (rst) begin
      sb.delete();
      prev_busy = 0;
      return;
    end
    if (rif.req_ready !== 3'b000) begin
      s = -1;
      for (int i = NR - 1; i >= 0; i--)
        if (rif.req_valid[i]) s = i;
      er = (s < 0) ? 3'b000 : 3'(1 << s);
      check("grant_onehot", 32'(rif.req_ready), 32'(er));
      if (s >= 0) begin
        v = int'(rif.req_value[s*VW +: VW]);
        e.src = s;
        e.dig = m_bcd(v);
        e.blk = m_blank(v);
        sb.push_back(e);
      end
      granted = 1;
      g_total++;
    end
    if (prev_busy && !busy) begin
      shown = 1;
      check("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("digits", 32'(digits), 32'(e.dig));
        check("active_src", 32'(asrc), 32'(e.src));
        check("disp_valid", 32'(dvalid), 1);
        check("blank", 32'(blank), 32'(e.blk));
      end
    end
    prev_busy = busy;
  endtask

  task automatic wait_grant(input string tag, input int maxc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!granted && n < maxc);
    check({tag, "_grant"}, 32'(granted), 1);
  endtask

  task automatic wait_show(input string tag, input int maxc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!shown && n < maxc);
    check({tag, "_shown"}, 32'(shown), 1);
  endtask

  initial begin
    int n;
    int idx;
    int prev_g;
    int ng;
    int g0;
    bit pend;
    int vals[4];

    vals[0] = 16383;
    vals[1] = 42;
    vals[2] = 0;
    vals[3] = 1005;

    rif.req_valid = '0;
    rif.req_value = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_digits", 32'(digits), 0);
    check("rst_blank", 32'(blank), 0);
    check("rst_dvalid", 32'(dvalid), 0);
    check("rst_asrc", 32'(asrc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(rif.req_ready), 0);

    // Source 1 alone, latency from CAPTURE entry to digits.
    set_val(1, 1234);
    rif.req_valid = 3'b010;
    wait_grant("t2", 10);
    check("t2_ready", 32'(rif.req_ready), 32'(3'b010));
    tick();
    n = 1;
    check("t2_pulse", 32'(rif.req_ready), 0);
    rif.req_valid = 3'b000;
    while (!shown && n < 40) begin
      tick();
      n++;
      if (n == 5) check("t2_no_flicker", 32'(digits), 0);
    end
    check("t2_latency", 32'(n), 15);
    check("t2_digits", 32'(digits), 32'h1234);
    repeat (HOLD + 3) tick();
    check("t2_idle_busy", 32'(busy), 0);
    check("t2_idle_keep", 32'(digits), 32'h1234);

    // Source 2 shown, source 0 arrives but may not preempt.
    set_val(2, 7);
    rif.req_valid = 3'b100;
    wait_grant("t3a", 10);
    tick();
    set_val(0, 9);
    rif.req_valid = 3'b001;
    wait_show("t3a", 30);
    n = 0;
    do begin
      tick();
      n++;
    end while (!granted && n < 40);
    check("t3_hold_len", 32'(n), HOLD);
    check("t3_held_val", 32'(digits), 32'h0007);
    tick();
    rif.req_valid = 3'b000;
    wait_show("t3b", 30);
    check("t3_digits", 32'(digits), 32'h0009);
    repeat (HOLD + 3) tick();

    // All valid: only source 0, fixed period, clamp and blanking.
    set_val(0, vals[0]);
    set_val(1, 11);
    set_val(2, 22);
    rif.req_valid = 3'b111;
    idx = 0;
    ng = 0;
    prev_g = 0;
    pend = 0;
    n = 0;
    while (ng < 4 && n < 200) begin
      tick();
      n++;
      if (pend) begin
        pend = 0;
        idx++;
        if (idx < 4) set_val(0, vals[idx]);
        else rif.req_valid = 3'b000;
      end
      if (granted) begin
        check("t4_src0", 32'(rif.req_ready), 1);
        if (ng > 0)
          check("t4_period", 32'(cyc - prev_g), 1 + VW + HOLD);
        prev_g = cyc;
        ng++;
        pend = 1;
      end
    end
    check("t4_grants", 32'(ng), 4);
    tick();
    rif.req_valid = 3'b000;
    wait_show("t4", 30);
    g0 = g_total;
    repeat (HOLD + 4) tick();
    check("t4_no_regrant", 32'(g_total), 32'(g0));
    check("t4_last", 32'(digits), 32'h1005);

    // Reset in the middle of a conversion.
    set_val(0, 5555);
    rif.req_valid = 3'b001;
    wait_grant("t1", 10);
    tick();
    rif.req_valid = 3'b000;
    repeat (3) tick();
    check("t1_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    repeat (3) tick();
    check("t1_digits", 32'(digits), 0);
    check("t1_dvalid", 32'(dvalid), 0);
    check("t1_busy", 32'(busy), 0);
    check("t1_blank", 32'(blank), 0);
    rst = 1'b0;
    tick();
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_ready", 32'(rif.req_ready), 0);
    repeat (20) tick();
    check("t1_no_partial", 32'(digits), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
